// File: rtl/aes_mixcol_pkg.sv
// Shared types and GF(2^8) helpers for the pipelined AES MixColumns datapath.
// The MixColumns / InvMixColumns column transform lives here as a pure
// function so the top can replicate it once per column.
package aes_mixcol_pkg;

    // AES field polynomial x^8+x^4+x^3+x+1 with the x^8 term dropped.
    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef logic [31:0] col_t;

    typedef enum logic {
        MC_FWD = 1'b0,
        MC_INV = 1'b1
    } mc_mode_e;

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Multiply by a small constant (every MixColumns coefficient fits in 4 bits).
    function automatic logic [7:0] gmul_const(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
    endfunction

    // One column through the circulant matrix; byte 0 sits in bits [31:24].
    function automatic col_t mixcol_word(input col_t word, input mc_mode_e inv);
        logic [3:0] k [4];
        logic [7:0] acc;
        col_t       res;
        if (inv == MC_INV) begin
            k[0] = 4'he; k[1] = 4'hb; k[2] = 4'hd; k[3] = 4'h9;
        end else begin
            k[0] = 4'h2; k[1] = 4'h3; k[2] = 4'h1; k[3] = 4'h1;
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
                // Row r of a circulant uses the first-row coefficient (j - r) mod 4.
                acc ^= gmul_const(8'(word >> (24 - 8 * j)), k[2'(j - r)]);
            end
            res = {res[23:0], acc};
        end
        return res;
    endfunction

    // Even parity of each byte of a column; bit 3 covers byte 0.
    function automatic logic [3:0] byte_parity(input col_t word);
        logic [3:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            p = {p[2:0], ^(8'(word >> (24 - 8 * i)))};
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_mixcol_stage.sv
// One valid/ready pipeline register holding a beat's data, tag and (when
// AES_MIXCOL_PARITY_EN is defined) its predicted byte parity. Loads whenever
// it is empty or its downstream is taking the current beat, so bubbles collapse.
module aes_mixcol_stage
    import aes_mixcol_pkg::*;
#(
    parameter int DW    = 128,
    parameter int TAG_W = 4
`ifdef AES_MIXCOL_PARITY_EN
    ,
    parameter int PW    = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic [TAG_W-1:0] in_tag,
`ifdef AES_MIXCOL_PARITY_EN
    input  logic [PW-1:0]    in_par,
    output logic [PW-1:0]    out_par,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic             valid_q;
    logic [DW-1:0]    data_q;
    logic [TAG_W-1:0] tag_q;

    assign in_ready  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_tag   = tag_q;

    // Stage register: take a new beat (or a bubble) whenever this stage can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data/tag are cleared too so a reset pipe shows all-zero outputs;
            // non-blocking assignments keep every stage sampling pre-edge values.
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
                tag_q  <= in_tag;
            end
        end
    end

`ifdef AES_MIXCOL_PARITY_EN
    logic [PW-1:0] par_q;

    assign out_par = par_q;

    // Predicted parity travels in lockstep with its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= '0;
        end else if (in_ready && in_valid) begin
            par_q <= in_par;
        end
    end
`endif

endmodule

// File: rtl/aes_mixcol_pipe.sv
// Pipelined AES MixColumns / InvMixColumns: NUM_COLS columns per beat, a
// per-beat mode bit, valid/ready on both sides and an occupancy counter.
// The transform sits in front of the first stage register; later stages only
// carry the beat. Optional byte-parity protection: AES_MIXCOL_PARITY_EN.
module aes_mixcol_pipe
    import aes_mixcol_pkg::*;
#(
    parameter  int NUM_COLS    = 4,
    parameter  int PIPE_STAGES = 2,
    parameter  int TAG_W       = 4,
    localparam int DW          = 32 * NUM_COLS,
    localparam int OCC_W       = $clog2(PIPE_STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [OCC_W-1:0] occupancy,
    output logic             out_perr
);

    // Index 0 is the upstream side, index PIPE_STAGES the downstream side.
    logic             stg_valid [PIPE_STAGES+1];
    logic             stg_ready [PIPE_STAGES+1];
    logic [DW-1:0]    stg_data  [PIPE_STAGES+1];
    logic [TAG_W-1:0] stg_tag   [PIPE_STAGES+1];
    logic [DW-1:0]    mixed;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        assign mixed[32*c +: 32] = mixcol_word(in_data[32*c +: 32], mc_mode_e'(in_inv));
    end

    assign stg_valid[0]           = in_valid;
    assign stg_data[0]            = mixed;
    assign stg_tag[0]             = in_tag;
    assign stg_ready[PIPE_STAGES] = out_ready;
    assign in_ready               = stg_ready[0];
    assign out_valid              = stg_valid[PIPE_STAGES];
    assign out_data               = stg_data[PIPE_STAGES];
    assign out_tag                = stg_tag[PIPE_STAGES];

`ifdef AES_MIXCOL_PARITY_EN
    localparam int PW = 4 * NUM_COLS;

    logic [PW-1:0] stg_par [PIPE_STAGES+1];
    logic [PW-1:0] pred_par;
    logic [PW-1:0] out_par_act;

    // Parity is predicted at the transform so any later register upset is caught.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_par
        assign pred_par[4*c +: 4]    = byte_parity(mixed[32*c +: 32]);
        assign out_par_act[4*c +: 4] = byte_parity(out_data[32*c +: 32]);
    end

    assign stg_par[0] = pred_par;
`endif

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        aes_mixcol_stage #(
            .DW    (DW),
            .TAG_W (TAG_W)
`ifdef AES_MIXCOL_PARITY_EN
            ,
            .PW    (PW)
`endif
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (stg_valid[s]),
            .in_ready  (stg_ready[s]),
            .in_data   (stg_data[s]),
            .in_tag    (stg_tag[s]),
`ifdef AES_MIXCOL_PARITY_EN
            .in_par    (stg_par[s]),
            .out_par   (stg_par[s+1]),
`endif
            .out_valid (stg_valid[s+1]),
            .out_ready (stg_ready[s+1]),
            .out_data  (stg_data[s+1]),
            .out_tag   (stg_tag[s+1])
        );
    end

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Beats in flight: accept and emit in the same cycle leave the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef AES_MIXCOL_PARITY_EN
    // Sticky error: any emitted beat whose bytes disagree with the carried parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_perr <= 1'b0;
        end else if (out_fire && (out_par_act != stg_par[PIPE_STAGES])) begin
            out_perr <= 1'b1;
        end
    end
`else
    assign out_perr = 1'b0;
`endif

endmodule

// File: tb/tb_aes_mixcol_pipe.sv
// Self-checking bench for aes_mixcol_pipe. Two instances share clock/reset:
// a single-column 2-stage pipe for the known-answer vectors and latency, and
// a four-column 3-stage pipe for streaming, backpressure, bubbles and reset.
// Expected data come from a GF(2^8) model using carry-less multiply + reduction.
module tb_aes_mixcol_pipe;

    localparam int S_PS = 2;
    localparam int B_PS = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Small instance: NUM_COLS=1, PIPE_STAGES=2.
    logic        s_in_valid = 1'b0, s_in_ready, s_in_inv = 1'b0;
    logic [31:0] s_in_data = '0, s_out_data;
    logic [3:0]  s_in_tag = '0, s_out_tag;
    logic        s_out_valid, s_out_ready = 1'b1, s_out_perr;
    logic [1:0]  s_occ;
    logic [31:0] s_exp = '0;

    // Big instance: NUM_COLS=4, PIPE_STAGES=3.
    logic         b_in_valid = 1'b0, b_in_ready, b_in_inv = 1'b0;
    logic [127:0] b_in_data = '0, b_out_data;
    logic [3:0]   b_in_tag = '0, b_out_tag;
    logic         b_out_valid, b_out_ready = 1'b1, b_out_perr;
    logic [1:0]   b_occ;
    logic [127:0] b_exp = '0;

    aes_mixcol_pipe #(.NUM_COLS(1), .PIPE_STAGES(S_PS), .TAG_W(4)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_inv(s_in_inv), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_tag(s_out_tag), .occupancy(s_occ), .out_perr(s_out_perr)
    );

    aes_mixcol_pipe #(.NUM_COLS(4), .PIPE_STAGES(B_PS), .TAG_W(4)) u_big (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_inv(b_in_inv), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .occupancy(b_occ), .out_perr(b_out_perr)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011B << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [7:0] first_row(input bit inv, input int idx);
        case (idx)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [31:0] ref_col(input logic [31:0] w, input bit inv);
        logic [7:0]  a [4];
        logic [7:0]  acc;
        logic [31:0] res;
        for (int j = 0; j < 4; j++) a[j] = 8'(w >> (24 - 8 * j));
        res = '0;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc ^= gf_mul(first_row(inv, (j - r + 4) % 4), a[j]);
            res = {res[23:0], acc};
        end
        return res;
    endfunction

    function automatic logic [127:0] ref_beat(input logic [127:0] d, input bit inv);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) res[32*c +: 32] = ref_col(d[32*c +: 32], inv);
        return res;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [127:0] data;
        logic [3:0]   tag;
        int           cyc;
    } exp_t;

    exp_t s_q[$];
    exp_t b_q[$];
    exp_t e;
    int   s_nout = 0, b_nout = 0;
    int   b_mark = 0, b_first_cyc = 0, b_last_cyc = 0;
    bit   b_chk_lat = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            s_q.delete();
            b_q.delete();
        end else begin
            check("s_occupancy", s_occ, s_q.size());
            if (s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) begin
                    check("s_spurious_out", s_out_valid, 1'b0);
                end else begin
                    e = s_q.pop_front();
                    check("s_data", s_out_data, e.data);
                    check("s_tag", s_out_tag, e.tag);
                    check("s_latency", cyc - e.cyc, S_PS);
                end
                s_nout++;
            end
            if (s_in_valid && s_in_ready) s_q.push_back('{{96'b0, s_exp}, s_in_tag, cyc});

            check("b_occupancy", b_occ, b_q.size());
            check("b_perr_clean", b_out_perr, 1'b0);
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) begin
                    check("b_spurious_out", b_out_valid, 1'b0);
                end else begin
                    e = b_q.pop_front();
                    check("b_data", b_out_data, e.data);
                    check("b_tag", b_out_tag, e.tag);
                    if (b_chk_lat) check("b_latency", cyc - e.cyc, B_PS);
                end
                if (b_nout == b_mark) b_first_cyc = cyc;
                b_last_cyc = cyc;
                b_nout++;
            end
            if (b_in_valid && b_in_ready) b_q.push_back('{b_exp, b_in_tag, cyc});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_s(input logic [3:0] tag);
        s_in_data = $urandom;
        s_in_inv  = 1'($urandom_range(0, 1));
        s_in_tag  = tag;
        s_exp     = ref_col(s_in_data, s_in_inv);
    endtask

    task automatic set_b(input logic [3:0] tag, input bit inv);
        b_in_data = {$urandom, $urandom, $urandom, $urandom};
        b_in_inv  = inv;
        b_in_tag  = tag;
        b_exp     = ref_beat(b_in_data, inv);
    endtask

    task automatic drain_b();
        for (int k = 0; k < 20 && (b_occ != 0 || b_out_valid); k++) tick();
        check("b_drain_occ", b_occ, 0);
    endtask

    logic [31:0] vin  [5] = '{32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'h8e4da1bc};
    logic [31:0] vexp [5] = '{32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6, 32'hd5d5d7d6, 32'hdb135345};
    bit          vinv [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] s_flip;
    int          n0;
    int          n_acc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #3;
        check("rst_s_valid", s_out_valid, 1'b0);
        check("rst_s_occ", s_occ, 0);
        check("rst_s_data", s_out_data, 0);
        check("rst_s_rdy", s_in_ready, 1'b1);
        check("rst_b_valid", b_out_valid, 1'b0);
        check("rst_b_occ", b_occ, 0);
        check("rst_b_data", b_out_data, 0);
        check("rst_b_tag", b_out_tag, 0);
        check("rst_s_perr", s_out_perr, 1'b0);
        rst_n = 1'b1;

        // ---- known-answer vectors then random beats, small pipe ----
        for (int i = 0; i < 5; i++) begin
            tick();
            s_in_valid = 1'b1;
            s_in_data  = vin[i];
            s_in_inv   = vinv[i];
            s_in_tag   = 4'(i);
            s_exp      = vexp[i];
            #2 check("s_kat_rdy", s_in_ready, 1'b1);
        end
        for (int i = 5; i < 11; i++) begin
            tick();
            s_in_valid = 1'b1;
            set_s(4'(i));
        end
        tick();
        s_in_valid = 1'b0;
        repeat (5) tick();
        check("s_count", s_nout, 11);

        // ---- back-to-back stream, big pipe ----
        b_chk_lat = 1'b1;
        n0 = b_nout;
        b_mark = b_nout;
        for (int i = 0; i < 8; i++) begin
            tick();
            b_in_valid = 1'b1;
            set_b(4'(i), i[0]);
            #2 check("b_stream_rdy", b_in_ready, 1'b1);
        end
        tick();
        b_in_valid = 1'b0;
        repeat (6) tick();
        check("b_stream_count", b_nout - n0, 8);
        check("b_stream_span", b_last_cyc - b_first_cyc, 7);
        b_chk_lat = 1'b0;

        // ---- backpressure: 3-deep pipe, 4 beats offered ----
        n0 = b_nout;
        n_acc = 0;
        tick();
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        set_b(4'(8), 1'b0);
        for (int k = 0; k < 6; k++) begin
            #2;
            check("b_bp_rdy", b_in_ready, k < 3);
            if (k >= 3) begin
                check("b_bp_valid", b_out_valid, 1'b1);
                check("b_bp_hold", b_out_data, b_q[0].data);
                check("b_bp_occ", b_occ, 3);
            end
            if (b_in_ready) n_acc++;
            tick();
            if (k < 3) set_b(4'(9 + k), 1'(k));
        end
        check("b_bp_accepted", n_acc, 3);
        b_out_ready = 1'b1;
        #2 check("b_bp_release_rdy", b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b0;
        drain_b();
        check("b_bp_count", b_nout - n0, 4);

        // ---- bubble collapse ----
        n0 = b_nout;
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        set_b(4'h3, 1'b0);
        #2 check("b_bub_rdy_a", b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b0;
        #2 check("b_bub_rdy_idle", b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b1;
        set_b(4'h5, 1'b1);
        #2 check("b_bub_rdy_b", b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b0;
        repeat (3) tick();
        #2;
        check("b_bub_occ", b_occ, 2);
        check("b_bub_head_tag", b_out_tag, 4'h3);
        check("b_bub_head", b_out_data, b_q[0].data);
        check("b_bub_rdy_room", b_in_ready, 1'b1);
        b_out_ready = 1'b1;
        tick();
        #2;
        check("b_bub_next_valid", b_out_valid, 1'b1);
        check("b_bub_next_tag", b_out_tag, 4'h5);
        drain_b();
        check("b_bub_count", b_nout - n0, 2);

        // ---- asynchronous reset with beats in flight ----
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        set_b(4'h7, 1'b0);
        tick();
        set_b(4'h8, 1'b1);
        tick();
        b_in_valid = 1'b0;
        repeat (3) tick();
        #2 check("b_prereset_valid", b_out_valid, 1'b1);
        n0 = b_nout;
        #1 rst_n = 1'b0;
        #1;
        check("b_reset_valid", b_out_valid, 1'b0);
        check("b_reset_occ", b_occ, 0);
        check("b_reset_data", b_out_data, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        b_out_ready = 1'b1;
        repeat (6) tick();
        check("b_reset_no_stale", b_nout - n0, 0);

`ifdef AES_MIXCOL_PARITY_EN
        // ---- parity: clean run, then an upset in the last stage register ----
        check("s_perr_clean", s_out_perr, 1'b0);
        tick();
        s_in_valid = 1'b1;
        set_s(4'hA);
        tick();
        s_in_valid = 1'b0;
        tick();
        @(negedge clk);
        #1;
        check("s_perr_pre", s_out_perr, 1'b0);
        s_flip = s_out_data ^ 32'h0000_0100;
        force u_small.g_stage[1].u_stage.data_q = s_flip;
        @(posedge clk);
        #1;
        release u_small.g_stage[1].u_stage.data_q;
        check("s_perr_set", s_out_perr, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            s_in_valid = 1'b1;
            set_s(4'(i));
        end
        tick();
        s_in_valid = 1'b0;
        repeat (4) tick();
        check("s_perr_sticky", s_out_perr, 1'b1);
`else
        check("s_perr_off", s_out_perr, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
